// File: rtl/rally_sequencer_if.sv
// Judge/physics-facing control bundle of the rally sequencer.
interface rally_sequencer_if;
    localparam int unsigned COORD_W = 12;
    localparam int unsigned CD_W    = 2;

    logic               tick;
    logic               start_btn;
    logic               point_pulse;
    logic               point_winner;
    logic               endgame;
    logic               pause_btn;
    logic               freeze;
    logic               ball_load;
    logic [COORD_W-1:0] ball_x_init;
    logic [COORD_W-1:0] ball_y_init;
    logic               serve_side;
    logic [CD_W-1:0]    countdown;
    logic               game_over;

    modport slave (
        input  tick, start_btn, point_pulse, point_winner, endgame, pause_btn,
        output freeze, ball_load, ball_x_init, ball_y_init, serve_side, countdown, game_over
    );

    modport master (
        output tick, start_btn, point_pulse, point_winner, endgame, pause_btn,
        input  freeze, ball_load, ball_x_init, ball_y_init, serve_side, countdown, game_over
    );
endinterface

// File: rtl/rally_sequencer.sv
// Rally sequencer: freezes physics between points, serves the ball and runs a 3-2-1 countdown.
// Optional PAUSED state when built with `define PAUSE_EN.
module rally_sequencer #(
    parameter int unsigned HOLD_TICKS = 60,
    parameter int unsigned STEP_TICKS = 30,
    parameter int unsigned SERVE_X1   = 200,
    parameter int unsigned SERVE_X2   = 824,
    parameter int unsigned SERVE_Y    = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    rally_sequencer_if.slave   bus
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned COORD_W = 12;
    localparam int unsigned CD_W    = 2;

    localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [COORD_W-1:0] X1        = COORD_W'(SERVE_X1);
    localparam logic [COORD_W-1:0] X2        = COORD_W'(SERVE_X2);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SETUP      = 3'd1,
        S_COUNTDOWN  = 3'd2,
        S_PLAY       = 3'd3,
        S_POINT_HOLD = 3'd4,
        S_GAME_OVER  = 3'd5,
        S_PAUSED     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic               ss_q, ss_d;
    logic               freeze_q, freeze_d;
    logic               load_q, load_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic               go_q, go_d;
    logic               start_prev_q;
    logic               start_rise;
    logic               enter_setup;

    assign start_rise = bus.start_btn & ~start_prev_q;

`ifdef PAUSE_EN
    logic pause_prev_q;
    logic pause_rise;

    assign pause_rise = bus.pause_btn & ~pause_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pause_prev_q <= 1'b0;
        else        pause_prev_q <= bus.pause_btn;
    end
`else
    logic unused_pause;

    assign unused_pause = bus.pause_btn;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cd_d        = cd_q;
        ss_d        = ss_q;
        freeze_d    = freeze_q;
        load_d      = 1'b0;
        x_d         = x_q;
        go_d        = go_q;
        enter_setup = 1'b0;

        case (state_q)
            S_IDLE: begin
                freeze_d = 1'b1;
                if (bus.endgame) begin
                    state_d = S_GAME_OVER;
                    go_d    = 1'b1;
                end else if (bus.start_btn) begin
                    enter_setup = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_COUNTDOWN;
                cd_d    = CD_W'(3);
                cnt_d   = '0;
            end
            S_COUNTDOWN: begin
                if (bus.tick) begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        if (cd_q == CD_W'(1)) begin
                            state_d  = S_PLAY;
                            cd_d     = '0;
                            freeze_d = 1'b0;
                        end else begin
                            cd_d = cd_q - CD_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                // A point outranks a simultaneous tick; the hold count starts from zero.
                if (bus.point_pulse) begin
                    state_d  = S_POINT_HOLD;
                    ss_d     = bus.point_winner;
                    cnt_d    = '0;
                    freeze_d = 1'b1;
                end
`ifdef PAUSE_EN
                else if (pause_rise) begin
                    state_d  = S_PAUSED;
                    freeze_d = 1'b1;
                end
`endif
            end
`ifdef PAUSE_EN
            S_PAUSED: begin
                if (pause_rise) begin
                    state_d  = S_PLAY;
                    freeze_d = 1'b0;
                end
            end
`endif
            S_POINT_HOLD: begin
                if (bus.tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        if (bus.endgame) begin
                            state_d = S_GAME_OVER;
                            go_d    = 1'b1;
                        end else begin
                            enter_setup = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAME_OVER: begin
                if (start_rise) begin
                    ss_d        = 1'b0;
                    go_d        = 1'b0;
                    enter_setup = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                cd_d     = '0;
                ss_d     = 1'b0;
                freeze_d = 1'b1;
                x_d      = X1;
                go_d     = 1'b0;
            end
        endcase

        // Serve position follows the side that will serve after this transition.
        if (enter_setup) begin
            state_d  = S_SETUP;
            load_d   = 1'b1;
            freeze_d = 1'b1;
            x_d      = ss_d ? X2 : X1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cd_q         <= '0;
            ss_q         <= 1'b0;
            freeze_q     <= 1'b1;
            load_q       <= 1'b0;
            x_q          <= X1;
            go_q         <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cd_q         <= cd_d;
            ss_q         <= ss_d;
            freeze_q     <= freeze_d;
            load_q       <= load_d;
            x_q          <= x_d;
            go_q         <= go_d;
            start_prev_q <= bus.start_btn;
        end
    end

    assign bus.freeze      = freeze_q;
    assign bus.ball_load   = load_q;
    assign bus.ball_x_init = x_q;
    assign bus.ball_y_init = COORD_W'(SERVE_Y);
    assign bus.serve_side  = ss_q;
    assign bus.countdown   = cd_q;
    assign bus.game_over   = go_q;
endmodule

// File: tb/tb_rally_sequencer.sv
// Scoreboard bench for rally_sequencer: every expected output change is queued by the stimulus
// and popped by a monitor whenever the DUT outputs change.
module tb_rally_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    rally_sequencer_if bus ();

    rally_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        freeze;
        logic        load;
        logic [11:0] x;
        logic [11:0] y;
        logic        ss;
        logic [1:0]  cd;
        logic        go;
    } snap_t;

    snap_t sb[$];
    string tags[$];
    int    checks = 0;
    int    fails  = 0;

    function automatic snap_t sample();
        snap_t s;
        s.freeze = bus.freeze;
        s.load   = bus.ball_load;
        s.x      = bus.ball_x_init;
        s.y      = bus.ball_y_init;
        s.ss     = bus.serve_side;
        s.cd     = bus.countdown;
        s.go     = bus.game_over;
        return s;
    endfunction

    task automatic push(input string tag, input logic f, input logic l, input int x,
                        input logic ss, input int cd, input logic go);
        snap_t s;
        s.freeze = f;
        s.load   = l;
        s.x      = 12'(x);
        s.y      = 12'd300;
        s.ss     = ss;
        s.cd     = 2'(cd);
        s.go     = go;
        sb.push_back(s);
        tags.push_back(tag);
    endtask

    // Monitor: any change of the output vector must match the oldest queued expectation.
    initial begin : monitor
        snap_t cur, prev, exp_s;
        string tg;
        bit    have = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            cur = sample();
            if (!have || cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: got %h, nothing expected", cur);
                end else begin
                    exp_s = sb.pop_front();
                    tg    = tags.pop_front();
                    if (cur !== exp_s) begin
                        fails++;
                        $display("FAIL %s: got %h expected %h", tg, cur, exp_s);
                    end
                end
            end
            prev = cur;
            have = 1'b1;
        end
    end

    task automatic drain(input string n);
        int k = 0;
        while (sb.size() != 0 && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected changes missing, required 0", n, sb.size());
            sb.delete();
            tags.delete();
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            cycles(1);
            bus.tick = 1'b0;
            cycles(1);
        end
    endtask

    task automatic pulse_start();
        bus.start_btn = 1'b1;
        cycles(1);
        bus.start_btn = 1'b0;
    endtask

    task automatic pulse_point(input logic w, input logic with_tick);
        bus.point_winner = w;
        bus.point_pulse  = 1'b1;
        bus.tick         = with_tick;
        cycles(1);
        bus.point_pulse  = 1'b0;
        bus.tick         = 1'b0;
    endtask

    task automatic run_countdown(input int x, input logic ss);
        tick_n(29);
        push("countdown_2", 1, 0, x, ss, 2, 0);
        tick_n(1);
        drain("countdown_2");
        tick_n(29);
        push("countdown_1", 1, 0, x, ss, 1, 0);
        tick_n(1);
        drain("countdown_1");
        tick_n(29);
        push("enter_play", 0, 0, x, ss, 0, 0);
        tick_n(1);
        drain("enter_play");
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.tick         = 1'b0;
        bus.start_btn    = 1'b0;
        bus.point_pulse  = 1'b0;
        bus.point_winner = 1'b0;
        bus.endgame      = 1'b0;
        bus.pause_btn    = 1'b0;

        push("reset_values", 1, 0, 200, 0, 0, 0);
        #2 rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        drain("reset_values");

        // First serve by player 1, point ignored outside PLAY.
        push("setup_load_p1", 1, 1, 200, 0, 0, 0);
        push("countdown_3", 1, 0, 200, 0, 3, 0);
        pulse_start();
        drain("first_setup");
        pulse_point(1'b1, 1'b0);
        cycles(2);
        run_countdown(200, 0);

        // Point with a simultaneous tick; hold count starts from zero.
        push("point_hold_p2", 1, 0, 200, 1, 0, 0);
        pulse_point(1'b1, 1'b1);
        drain("point_hold_p2");
        tick_n(10);
        pulse_point(1'b0, 1'b0);
        tick_n(49);
        push("setup_load_p2", 1, 1, 824, 1, 0, 0);
        push("countdown_3_p2", 1, 0, 824, 1, 3, 0);
        tick_n(1);
        drain("serve_p2");
        run_countdown(824, 1);

        // Final point with endgame; start held from before GAME_OVER gives no exit.
        push("point_hold_p1", 1, 0, 824, 0, 0, 0);
        pulse_point(1'b0, 1'b0);
        drain("point_hold_p1");
        bus.endgame = 1'b1;
        tick_n(50);
        bus.start_btn = 1'b1;
        tick_n(9);
        push("game_over", 1, 0, 824, 0, 0, 1);
        tick_n(1);
        drain("game_over");
        cycles(10);
        bus.start_btn = 1'b0;
        bus.endgame   = 1'b0;
        cycles(2);
        push("restart_setup", 1, 1, 200, 0, 0, 0);
        push("restart_countdown", 1, 0, 200, 0, 3, 0);
        pulse_start();
        drain("restart");

        // Asynchronous reset mid-countdown.
        tick_n(29);
        push("countdown_2_pre_reset", 1, 0, 200, 0, 2, 0);
        tick_n(1);
        drain("countdown_2_pre_reset");
        tick_n(5);
        #1;
        push("async_reset", 1, 0, 200, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL async_reset_no_clk: %0d pending, required 0", sb.size());
        end
        cycles(1);
        rst_n = 1'b1;
        drain("async_reset");

        // endgame sampled in IDLE, then edge exit.
        bus.endgame = 1'b1;
        push("idle_endgame", 1, 0, 200, 0, 0, 1);
        cycles(1);
        drain("idle_endgame");
        bus.endgame = 1'b0;
        cycles(1);
        push("exit_setup", 1, 1, 200, 0, 0, 0);
        push("exit_countdown", 1, 0, 200, 0, 3, 0);
        pulse_start();
        drain("exit_game_over");
        run_countdown(200, 0);

`ifdef PAUSE_EN
        push("paused", 1, 0, 200, 0, 0, 0);
        bus.pause_btn = 1'b1;
        cycles(1);
        drain("paused");
        pulse_point(1'b1, 1'b0);
        bus.pause_btn = 1'b0;
        cycles(2);
        push("resumed", 0, 0, 200, 0, 0, 0);
        bus.pause_btn = 1'b1;
        cycles(1);
        drain("resumed");
        bus.pause_btn = 1'b0;
        cycles(1);
`else
        repeat (4) begin
            bus.pause_btn = ~bus.pause_btn;
            cycles(1);
        end
`endif
        push("final_point", 1, 0, 200, 1, 0, 0);
        pulse_point(1'b1, 1'b0);
        drain("final_point");

        cycles(4);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL queue_empty: %0d left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rally_sequencer.md
Name: rally_sequencer

Overview:
Sequences each rally around the scoring judge. It freezes ball/player physics between points, repositions the ball on the serving side, and runs a visible 3-2-1 countdown. It then releases play until the judge reports a point or end of game. It sits between the judge and the ball/player physics blocks, clocked by the 65 MHz pixel clock, and advances its timers on the frame tick.

Parameters:
HOLD_TICKS, 60, frame ticks spent in POINT_HOLD after a point (1..255)
STEP_TICKS, 30, frame ticks per countdown step (1..255)
SERVE_X1, 200, ball x init when player 1 serves (12 bit)
SERVE_X2, 824, ball x init when player 2 serves (12 bit)
SERVE_Y, 300, ball y init for either serve (12 bit)

Ports:
clk  in  1  system clock, 65 MHz
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle frame tick (vsync-derived)
start_btn  in  1  level; start game from IDLE
point_pulse  in  1  one-cycle pulse, judge scored a point
point_winner  in  1  0 = player1 won the point, 1 = player2
endgame  in  1  level from judge; game finished
pause_btn  in  1  level; used only with PAUSE_EN
freeze  out  1  1 = physics hold ball/players
ball_load  out  1  one-cycle pulse; physics loads ball_x_init/ball_y_init
ball_x_init  out  12  serve x position
ball_y_init  out  12  serve y position
serve_side  out  1  0 = player1 serves, 1 = player2
countdown  out  2  3,2,1 during COUNTDOWN, else 0
game_over  out  1  1 in GAME_OVER

Behaviour:
- Reset (async assert, sync release) puts the FSM in IDLE with these outputs: freeze=1, ball_load=0, serve_side=0, countdown=0, game_over=0, ball_x_init=SERVE_X1, ball_y_init=SERVE_Y. Tick counter resets to 0. All registers clear the same way on a mid-operation reset.
- Registered outputs. Every output changes one clk after the state change.
- States:
  - IDLE: freeze=1. start_btn=1 -> SETUP.
  - SETUP: a single clk. ball_x_init = SERVE_X1 if serve_side=0, else SERVE_X2. ball_load pulses 1 clk. -> COUNTDOWN with countdown=3 and the counter cleared.
  - COUNTDOWN: freeze=1.
    - Counter increments only on clk cycles with tick=1.
    - When the counter reaches STEP_TICKS-1 and tick=1: the counter clears and countdown decrements.
    - When countdown=1 expires -> PLAY with countdown=0.
  - PLAY: freeze=0. point_pulse=1 -> POINT_HOLD. On that same clk, serve_side <= point_winner (the winner serves) and the counter clears.
  - POINT_HOLD: freeze=1. Counts ticks up to HOLD_TICKS-1. On expiry: endgame=1 -> GAME_OVER, else -> SETUP.
  - GAME_OVER: freeze=1, game_over=1. Exits only on a rising edge of start_btn (registered previous value). On exit: serve_side <= 0 -> SETUP.
- point_pulse outside PLAY is ignored.
- endgame is sampled only at the end of POINT_HOLD and in IDLE. endgame=1 in IDLE -> GAME_OVER.
- A tick and a point_pulse in the same clk in PLAY: the point wins, and the counter starts from 0.
- start_btn held through IDLE -> SETUP -> ... has no further effect. Only the GAME_OVER exit is edge-triggered.
- Counter width is 8 bits. It never wraps, because it clears at each terminal count.
- Illegal or unused state encoding -> IDLE with outputs at reset values.

Optional Feature:
PAUSE_EN
- Defined: adds a PAUSED state, entered from PLAY on a rising edge of pause_btn. PAUSED holds freeze=1 and ignores point_pulse. Another rising edge returns to PLAY. Entry and exit do not disturb serve_side or the counter.
- Undefined: pause_btn is unused (left unconnected internally) and PAUSED does not exist.

Test Plan:
- Reset, then start_btn=1 for 1 clk -> SETUP then COUNTDOWN. ball_load pulses once with ball_x_init=200, ball_y_init=300. countdown=3.
- In COUNTDOWN, 90 ticks with STEP_TICKS=30 -> countdown goes 3,2,1. PLAY is entered on the clk after the 90th tick, with freeze=0 and countdown=0.
- In PLAY, point_pulse with point_winner=1 -> freeze=1, serve_side=1. After 60 ticks, SETUP loads ball_x_init=824. A point_pulse during the hold is ignored.
- endgame=1 during POINT_HOLD -> GAME_OVER after 60 ticks, game_over=1. start_btn held high gives no exit. Release then press -> SETUP with serve_side=0.
- rst_n low mid-COUNTDOWN -> outputs return to reset values immediately, without waiting for clk. countdown=0, freeze=1.
- PAUSE_EN defined: pause_btn edge in PLAY -> freeze=1, point_pulse ignored. Second edge -> PLAY with freeze=0. Undefined: pause_btn toggling has no effect.
